// File: rtl/apb_pkg.sv
// Shared APB definitions for the RAM arbiter and the 4 KiB word RAM slave.
//   apb_mst_state_e : APB master sequencing states
//   APB_ADDR_W      : APB byte-address width (0x000..0xFFF)
//   APB_DATA_W      : APB data width
package apb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant selection.
// Scans the request vector starting one past last_grant (wrapping modulo N)
// and returns the first set bit as both a one-hot grant and an index.
// The pointer register lives in the instantiating module.
//   req        in   N       request vector
//   last_grant in   IDX_W   index of the most recently served requester
//   grant      out  N       one-hot grant (all zero when no request)
//   grant_idx  out  IDX_W   index of the granted requester
//   any        out  1       at least one request pending
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last_grant) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/apb_ram_arbiter.sv
// Shares one APB slave (the 4 KiB word RAM) between NUM_REQ local requesters.
// Round-robin arbitration, then acts as APB master for the granted requester,
// waits on PREADY (bounded by TIMEOUT ACCESS cycles) and returns read data
// with a one-cycle done pulse. All outputs are registered.
//
//   state  | meaning
//   IDLE   | arbitrate among req_valid, latch grantee payload
//   SETUP  | PSEL=1, PENABLE=0, payload on the bus
//   ACCESS | PSEL=1, PENABLE=1, wait for PREADY or timeout
//   RESP   | bus released, req_done (and req_err on abort) to grantee
//
// Ports:
//   PCLK, PRESET                 clock, async active-high reset
//   req_valid/write/addr/wdata   packed requester inputs (requester i at [i*W +: W])
//   req_done, req_err            one-cycle completion / timeout pulses
//   rsp_rdata                    read data, valid while req_done high
//   PADDR..PENABLE               APB master outputs
//   PRDATA, PREADY               APB slave responses
module apb_ram_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  apb_mst_state_e       state, state_nxt;
  logic [IDX_W-1:0]     last_grant, last_grant_nxt;
  logic [IDX_W-1:0]     grant_idx, grant_idx_nxt;
  logic [NUM_REQ-1:0]   grant_oh, grant_oh_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 abort, abort_nxt;
  logic                 psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0]    paddr_nxt;
  logic [DATA_W-1:0]    pwdata_nxt, rdata_nxt;
  logic [NUM_REQ-1:0]   done_nxt, err_nxt;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_idx_nxt  = grant_idx;
    grant_oh_nxt   = grant_oh;
    cnt_nxt        = cnt;
    abort_nxt      = abort;
    pwrite_nxt     = PWRITE;
    paddr_nxt      = PADDR;
    pwdata_nxt     = PWDATA;
    rdata_nxt      = rsp_rdata;

    case (state)
      IDLE: begin
        if (arb_any) begin
          grant_idx_nxt = arb_idx;
          grant_oh_nxt  = arb_grant;
          pwrite_nxt    = req_write[arb_idx];
          paddr_nxt     = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          pwdata_nxt    = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
          abort_nxt     = 1'b0;
          state_nxt     = SETUP;
        end
      end
      SETUP: begin
        // Timer reloads here so any PREADY seen before ACCESS never counts.
        cnt_nxt   = CNT_LOAD;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          if (!PWRITE) rdata_nxt = PRDATA;
          state_nxt = RESP;
        end else if (cnt == '0) begin
          abort_nxt = 1'b1;
          rdata_nxt = '0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        last_grant_nxt = grant_idx;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    psel_nxt    = (state_nxt == SETUP) || (state_nxt == ACCESS);
    penable_nxt = (state_nxt == ACCESS);
    done_nxt    = (state_nxt == RESP) ? grant_oh_nxt : '0;
    err_nxt     = (state_nxt == RESP && abort_nxt) ? grant_oh_nxt : '0;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_idx  <= '0;
      grant_oh   <= '0;
      cnt        <= '0;
      abort      <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_rdata  <= '0;
      req_done   <= '0;
      req_err    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_idx  <= grant_idx_nxt;
      grant_oh   <= grant_oh_nxt;
      cnt        <= cnt_nxt;
      abort      <= abort_nxt;
      PSEL       <= psel_nxt;
      PENABLE    <= penable_nxt;
      PWRITE     <= pwrite_nxt;
      PADDR      <= paddr_nxt;
      PWDATA     <= pwdata_nxt;
      rsp_rdata  <= rdata_nxt;
      req_done   <= done_nxt;
      req_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Directed bench for apb_ram_arbiter with a behavioural word-RAM APB slave
// (PREADY one cycle after PSEL&PENABLE). Knobs force PREADY low (timeout) or
// hold a stale PREADY high outside ACCESS.
module tb_apb_ram_arbiter;
  import apb_pkg::*;

  localparam int NR = 2;
  localparam int AW = APB_ADDR_W;
  localparam int DW = APB_DATA_W;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_write = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_done, req_err;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     PADDR;
  logic              PWRITE, PSEL, PENABLE, PREADY;
  logic [DW-1:0]     PWDATA, PRDATA;

  int n_checks = 0;
  int n_errors = 0;

  apb_ram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .rsp_rdata (rsp_rdata),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Word RAM slave model
  logic [DW-1:0] mem [0:1023];
  logic          ram_ready;
  logic          tie_low = 1'b0;
  logic          stale_en = 1'b0;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) ram_ready <= 1'b0;
    else        ram_ready <= PSEL & PENABLE;
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[11:2]] <= PWDATA;
  end

  assign PRDATA = mem[PADDR[11:2]];
  assign PREADY = tie_low ? 1'b0 : (ram_ready | (stale_en & ~PENABLE));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer from requester r; cycle 0 is the IDLE cycle that sees valid.
  task automatic do_xfer(input int r, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wd, output int done_cyc, output int psel_cyc,
                         output int acc, output logic [31:0] rd, output logic er,
                         output logic [11:0] pa, output logic psel_resp);
    @(posedge PCLK); #1;
    req_valid[r] = 1'b1;
    req_write[r] = wr;
    req_addr[r*AW +: AW]  = addr;
    req_wdata[r*DW +: DW] = wd;
    done_cyc = -1; psel_cyc = -1; acc = 0; rd = '0; er = 1'b0; pa = '0; psel_resp = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge PCLK); #1;
      if (PSEL && psel_cyc < 0) begin
        psel_cyc = c;
        pa = PADDR;
      end
      if (PSEL && PENABLE) acc++;
      if (req_done[r]) begin
        done_cyc  = c;
        rd        = rsp_rdata;
        er        = req_err[r];
        psel_resp = PSEL;
        break;
      end
    end
    req_valid[r] = 1'b0;
  endtask

  int got_idx [4];
  int got_cyc [4];

  // Both requesters held valid; records order and cycle of the first n done pulses.
  task automatic run_pair(input int n);
    int k;
    k = 0;
    @(posedge PCLK); #1;
    req_valid = '1;
    req_write = '1;
    req_addr  = {12'h024, 12'h020};
    req_wdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    for (int c = 1; c <= 80 && k < n; c++) begin
      @(posedge PCLK); #1;
      if (req_done != '0) begin
        got_idx[k] = (req_done == 2'b01) ? 0 : (req_done == 2'b10) ? 1 : 9;
        got_cyc[k] = c;
        k++;
      end
    end
    req_valid = '0;
    for (int i = k; i < n; i++) begin
      got_idx[i] = -1;
      got_cyc[i] = -1;
    end
  endtask

  int          done_cyc, psel_cyc, acc;
  logic [31:0] rd;
  logic        er, psel_resp, done_seen;
  logic [11:0] pa;

  initial begin
    // Reset values
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel",    32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite",  32'(PWRITE), 32'd0);
    chk("rst_paddr",   32'(PADDR), 32'd0);
    chk("rst_pwdata",  PWDATA, 32'd0);
    chk("rst_done",    32'(req_done), 32'd0);
    chk("rst_err",     32'(req_err), 32'd0);
    chk("rst_rdata",   rsp_rdata, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Single write
    do_xfer(0, 1'b1, 12'h010, 32'hDEAD_BEEF, done_cyc, psel_cyc, acc, rd, er, pa, psel_resp);
    chk("wr_psel_cyc", 32'(psel_cyc), 32'd1);
    chk("wr_acc_cyc",  32'(acc), 32'd2);
    chk("wr_done_cyc", 32'(done_cyc), 32'd4);
    chk("wr_paddr",    32'(pa), 32'h010);
    chk("wr_err",      32'(er), 32'd0);
    chk("wr_mem4",     mem[4], 32'hDEAD_BEEF);

    // Read-back by requester 1
    do_xfer(1, 1'b0, 12'h010, 32'h0, done_cyc, psel_cyc, acc, rd, er, pa, psel_resp);
    chk("rd_done_cyc", 32'(done_cyc), 32'd4);
    chk("rd_data",     rd, 32'hDEAD_BEEF);
    chk("rd_err",      32'(er), 32'd0);

    // Top address, low bits passed through unchanged
    do_xfer(0, 1'b1, 12'hFFF, 32'h0BAD_F00D, done_cyc, psel_cyc, acc, rd, er, pa, psel_resp);
    chk("top_paddr",   32'(pa), 32'hFFF);
    chk("top_mem1023", mem[1023], 32'h0BAD_F00D);
    do_xfer(1, 1'b0, 12'hFFC, 32'h0, done_cyc, psel_cyc, acc, rd, er, pa, psel_resp);
    chk("top_rd_data", rd, 32'h0BAD_F00D);

    // Timeout: PREADY held low
    tie_low = 1'b1;
    do_xfer(0, 1'b0, 12'h010, 32'h0, done_cyc, psel_cyc, acc, rd, er, pa, psel_resp);
    tie_low = 1'b0;
    chk("to_acc_cyc",   32'(acc), 32'd16);
    chk("to_done_cyc",  32'(done_cyc), 32'd18);
    chk("to_err",       32'(er), 32'd1);
    chk("to_rdata",     rd, 32'd0);
    chk("to_psel_resp", 32'(psel_resp), 32'd0);

    // Stale PREADY outside ACCESS, back-to-back transfers
    stale_en = 1'b1;
    do_xfer(1, 1'b1, 12'h044, 32'h1234_5678, done_cyc, psel_cyc, acc, rd, er, pa, psel_resp);
    chk("st_wr_acc",  32'(acc), 32'd2);
    chk("st_wr_done", 32'(done_cyc), 32'd4);
    do_xfer(0, 1'b0, 12'h044, 32'h0, done_cyc, psel_cyc, acc, rd, er, pa, psel_resp);
    chk("st_rd_acc",  32'(acc), 32'd2);
    chk("st_rd_done", 32'(done_cyc), 32'd4);
    chk("st_rd_data", rd, 32'h1234_5678);
    stale_en = 1'b0;

    // Reset during ACCESS of a requester-1 read (last grant was requester 0)
    @(posedge PCLK); #1;
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[AW +: AW] = 12'h010;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("mr_in_access", 32'(PENABLE), 32'd1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("mr_psel",    32'(PSEL), 32'd0);
    chk("mr_penable", 32'(PENABLE), 32'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge PCLK); #1;
      done_seen = done_seen | (|req_done);
    end
    req_valid = '0;
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (6) begin
      @(posedge PCLK); #1;
      done_seen = done_seen | (|req_done);
    end
    chk("mr_no_done", 32'(done_seen), 32'd0);

    // Contention after reset: req0 first, then alternating, 5-cycle cadence
    run_pair(4);
    chk("ct_grant0", 32'(got_idx[0]), 32'd0);
    chk("ct_grant1", 32'(got_idx[1]), 32'd1);
    chk("ct_grant2", 32'(got_idx[2]), 32'd0);
    chk("ct_grant3", 32'(got_idx[3]), 32'd1);
    chk("ct_cyc0",   32'(got_cyc[0]), 32'd4);
    chk("ct_cyc3",   32'(got_cyc[3]), 32'd19);
    chk("ct_mem8",   mem[8], 32'hA0A0_A0A0);
    chk("ct_mem9",   mem[9], 32'hB1B1_B1B1);

    repeat (3) @(posedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
